// File: rtl/timebase_gen_if.sv
// timebase_gen_if: divisor write channel of timebase_gen (strobe, target, value, ack/err).
`timescale 1ns/1ps
interface timebase_gen_if #(
  parameter int unsigned CNT_W = 27
);
  logic             div_wr;
  logic [2:0]       div_sel;
  logic [CNT_W-1:0] div_val;
  logic             div_ack;
  logic             div_err;

  modport master (
    output div_wr, div_sel, div_val,
    input  div_ack, div_err
  );

  modport slave (
    input  div_wr, div_sel, div_val,
    output div_ack, div_err
  );
endinterface

// File: rtl/timebase_gen.sv
// timebase_gen: NUM_CH independent tick dividers with shadowed (pending) divisor updates.
// Define TIMEBASE_PHASE_OUT_EN to add the per-channel phase square-wave output.
`timescale 1ns/1ps
module timebase_gen #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  timebase_gen_if.slave     div_bus,
  output logic [NUM_CH-1:0] tick
`ifdef TIMEBASE_PHASE_OUT_EN
  ,
  output logic [NUM_CH-1:0] phase
`endif
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(CLK_HZ);

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  div_q  [NUM_CH];
  logic [CNT_W-1:0]  div_d  [NUM_CH];
  logic [CNT_W-1:0]  pdiv_q [NUM_CH];
  logic [CNT_W-1:0]  pdiv_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sel_hit, wrap_hit;
  logic              wr_ok;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
`ifdef TIMEBASE_PHASE_OUT_EN
  logic [NUM_CH-1:0] phase_q, phase_d;
`endif

  always_comb begin
    wr_ok = div_bus.div_wr && (32'(div_bus.div_sel) < NUM_CH)
            && (div_bus.div_val >= CNT_W'(2));
    ack_d    = wr_ok;
    err_d    = div_bus.div_wr && !wr_ok;
    sel_hit  = '0;
    wrap_hit = '0;
    pend_d   = pend_q;
    tick_d   = '0;
`ifdef TIMEBASE_PHASE_OUT_EN
    phase_d  = phase_q;
`endif
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch]    = cnt_q[ch];
      div_d[ch]    = div_q[ch];
      pdiv_d[ch]   = pdiv_q[ch];
      sel_hit[ch]  = wr_ok && (div_bus.div_sel == 3'(ch));
      wrap_hit[ch] = (cnt_q[ch] == div_q[ch] - CNT_W'(1));

      if (clr) begin
        // A write landing with clr bypasses the pending stage and takes effect at once.
        cnt_d[ch] = '0;
        if (sel_hit[ch]) begin
          div_d[ch]  = div_bus.div_val;
          pdiv_d[ch] = div_bus.div_val;
        end else if (pend_q[ch]) begin
          div_d[ch] = pdiv_q[ch];
        end
        pend_d[ch] = 1'b0;
`ifdef TIMEBASE_PHASE_OUT_EN
        phase_d[ch] = 1'b0;
`endif
      end else begin
        if (en) begin
          if (wrap_hit[ch]) begin
            cnt_d[ch]  = '0;
            tick_d[ch] = 1'b1;
            if (pend_q[ch]) begin
              div_d[ch]  = pdiv_q[ch];
              pend_d[ch] = 1'b0;
            end
          end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
          end
`ifdef TIMEBASE_PHASE_OUT_EN
          phase_d[ch] = (cnt_d[ch] < (div_d[ch] >> 1));
`endif
        end
        // Evaluated after the wrap so the previously pending value is consumed first.
        if (sel_hit[ch]) begin
          pdiv_d[ch] = div_bus.div_val;
          pend_d[ch] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch]  <= '0;
        div_q[ch]  <= RST_DIV;
        pdiv_q[ch] <= RST_DIV;
      end
      pend_q <= '0;
      tick_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
`ifdef TIMEBASE_PHASE_OUT_EN
      phase_q <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
`ifdef TIMEBASE_PHASE_OUT_EN
      phase_q <= phase_d;
`endif
    end
  end

  assign tick            = tick_q;
  assign div_bus.div_ack = ack_q;
  assign div_bus.div_err = err_q;
`ifdef TIMEBASE_PHASE_OUT_EN
  assign phase           = phase_q;
`endif

endmodule

// File: tb/tb_timebase_gen.sv
// tb_timebase_gen: directed scenarios plus random traffic against a countdown-style reference model.
`timescale 1ns/1ps
module tb_timebase_gen;
  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned HZ  = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en  = 1'b0;
  logic           clr = 1'b0;
  logic [NCH-1:0] tick;
`ifdef TIMEBASE_PHASE_OUT_EN
  logic [NCH-1:0] phase;
`endif

  timebase_gen_if #(.CNT_W(CW)) bus ();

  timebase_gen #(.CLK_HZ(HZ), .NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .div_bus (bus),
    .tick    (tick)
`ifdef TIMEBASE_PHASE_OUT_EN
    ,
    .phase   (phase)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: remaining enabled cycles until the next tick per channel.
  int unsigned    m_rem  [NCH];
  int unsigned    m_div  [NCH];
  int unsigned    m_pdiv [NCH];
  bit             m_pend [NCH];
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_phase;
  logic           m_ack, m_err;

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_div[ch]  = HZ;
      m_pdiv[ch] = HZ;
      m_pend[ch] = 1'b0;
      m_rem[ch]  = HZ;
    end
    m_tick  = '0;
    m_phase = '0;
    m_ack   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic c, input logic w,
                            input logic [2:0] s, input logic [7:0] v);
    bit ok;
    bit hit;
    ok    = w && (int'(s) < NCH) && (int'(v) >= 2);
    m_ack = ok;
    m_err = w && !ok;
    for (int ch = 0; ch < NCH; ch++) begin
      hit        = ok && (int'(s) == ch);
      m_tick[ch] = 1'b0;
      if (c) begin
        if (hit) begin
          m_div[ch]  = v;
          m_pdiv[ch] = v;
        end else if (m_pend[ch]) begin
          m_div[ch] = m_pdiv[ch];
        end
        m_pend[ch]  = 1'b0;
        m_rem[ch]   = m_div[ch];
        m_phase[ch] = 1'b0;
      end else begin
        if (e) begin
          m_rem[ch]--;
          if (m_rem[ch] == 0) begin
            m_tick[ch] = 1'b1;
            if (m_pend[ch]) begin
              m_div[ch]  = m_pdiv[ch];
              m_pend[ch] = 1'b0;
            end
            m_rem[ch] = m_div[ch];
          end
          m_phase[ch] = ((m_div[ch] - m_rem[ch]) < (m_div[ch] / 2));
        end
        if (hit) begin
          m_pdiv[ch] = v;
          m_pend[ch] = 1'b1;
        end
      end
    end
  endtask

  task automatic run_cycle(input logic e, input logic c, input logic w,
                           input logic [2:0] s, input logic [7:0] v);
    en          = e;
    clr         = c;
    bus.div_wr  = w;
    bus.div_sel = s;
    bus.div_val = v;
    @(posedge clk);
    model_edge(e, c, w, s, v);
    #1;
    check_val("tick", 32'(tick), 32'(m_tick));
    check_val("ack", 32'(bus.div_ack), 32'(m_ack));
    check_val("err", 32'(bus.div_err), 32'(m_err));
    check_val("ack_err_excl", 32'(bus.div_ack & bus.div_err), 32'd0);
`ifdef TIMEBASE_PHASE_OUT_EN
    check_val("phase", 32'(phase), 32'(m_phase));
`endif
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases between edges.
  task automatic apply_reset();
    #2;
    rst         = 1'b0;
    en          = 1'b0;
    clr         = 1'b0;
    bus.div_wr  = 1'b0;
    bus.div_sel = '0;
    bus.div_val = '0;
    #1;
    check_val("rst_tick", 32'(tick), 32'd0);
    check_val("rst_ack", 32'(bus.div_ack), 32'd0);
    check_val("rst_err", 32'(bus.div_err), 32'd0);
`ifdef TIMEBASE_PHASE_OUT_EN
    check_val("rst_phase", 32'(phase), 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  logic [NCH-1:0] exp_t;
  logic           r_en, r_clr, r_wr;
  logic [2:0]     r_sel;
  logic [7:0]     r_val;

  initial begin
    bus.div_wr  = 1'b0;
    bus.div_sel = '0;
    bus.div_val = '0;

    // Plain divide-by-10 on every channel.
    apply_reset();
    for (int cyc = 1; cyc <= 35; cyc++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      check_val("s1_tick", 32'(tick), (cyc % 10 == 0) ? 32'hF : 32'h0);
    end

    // Channel 1 reprogrammed to 4 mid-period; old period completes first.
    apply_reset();
    for (int cyc = 1; cyc <= 25; cyc++) begin
      run_cycle(1'b1, 1'b0, (cyc - 1) == 3, 3'd1, 8'd4);
      exp_t = (cyc % 10 == 0) ? 4'b1101 : 4'b0000;
      if (cyc == 10 || (cyc > 10 && (cyc - 10) % 4 == 0)) exp_t[1] = 1'b1;
      check_val("s2_tick", 32'(tick), 32'(exp_t));
      check_val("s2_ack", 32'(bus.div_ack), 32'(cyc == 4));
    end

    // Rejected writes: divisor too small, then channel out of range.
    apply_reset();
    for (int cyc = 1; cyc <= 25; cyc++) begin
      run_cycle(1'b1, 1'b0, ((cyc - 1) == 2) || ((cyc - 1) == 4),
                ((cyc - 1) == 4) ? 3'd5 : 3'd0, ((cyc - 1) == 4) ? 8'd6 : 8'd1);
      check_val("s3_tick", 32'(tick), (cyc % 10 == 0) ? 32'hF : 32'h0);
      check_val("s3_err", 32'(bus.div_err), 32'(cyc == 3 || cyc == 5));
      check_val("s3_ack", 32'(bus.div_ack), 32'd0);
    end

    // Enable dropped for five cycles delays the tick by five.
    apply_reset();
    for (int cyc = 1; cyc <= 26; cyc++) begin
      run_cycle(!((cyc - 1) >= 5 && (cyc - 1) <= 9), 1'b0, 1'b0, 3'd0, 8'd0);
      check_val("s4a_tick0", 32'(tick[0]), 32'(cyc == 15 || cyc == 25));
    end

    // Pending divisor 3 on channel 2 applied immediately by clr.
    apply_reset();
    for (int cyc = 1; cyc <= 24; cyc++) begin
      run_cycle(1'b1, (cyc - 1) == 12, (cyc - 1) == 11, 3'd2, 8'd3);
      check_val("s4b_tick2", 32'(tick[2]),
                32'(cyc == 10 || (cyc >= 16 && (cyc - 16) % 3 == 0)));
      check_val("s4b_tick0", 32'(tick[0]), 32'(cyc == 10 || cyc == 23));
      check_val("s4b_ack", 32'(bus.div_ack), 32'(cyc == 12));
    end

    // Reset mid-period discards a pending write.
    apply_reset();
    for (int cyc = 1; cyc <= 7; cyc++) begin
      run_cycle(1'b1, 1'b0, (cyc - 1) == 2, 3'd0, 8'd5);
    end
    apply_reset();
    for (int cyc = 1; cyc <= 25; cyc++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      check_val("s5_tick", 32'(tick), (cyc % 10 == 0) ? 32'hF : 32'h0);
    end

    // Random traffic against the model.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      r_en  = ($urandom_range(0, 7) != 0);
      r_clr = ($urandom_range(0, 59) == 0);
      r_wr  = ($urandom_range(0, 3) == 0);
      r_sel = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      r_val = 8'($urandom_range(0, 14));
      run_cycle(r_en, r_clr, r_wr, r_sel, r_val);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timebase_gen.md
TIMEBASE_GEN -- requirements
Module: timebase_gen

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: input clock frequency; reset divisor of every channel.
REQ-002 Parameter NUM_CH, default 4: number of independent tick channels (1..8).
REQ-003 Parameter CNT_W, default 27: counter and divisor width; CLK_HZ SHALL fit in CNT_W bits.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 en  input  1  global count enable; low freezes all counters.
REQ-007 clr  input  1  synchronous restart of all channels.
REQ-008 div_wr  input  1  divisor write strobe, single-cycle.
REQ-009 div_sel  input  3  target channel of div_wr.
REQ-010 div_val  input  CNT_W  divisor value of div_wr.
REQ-011 div_ack  output  1  one-cycle pulse: write accepted.
REQ-012 div_err  output  1  one-cycle pulse: write rejected.
REQ-013 tick  output  NUM_CH  per-channel one-cycle enable pulse.
REQ-014 phase  output  NUM_CH  per-channel square wave (present only with TIMEBASE_PHASE_OUT_EN).

Function
REQ-015 Each channel SHALL hold an active divisor D, a pending divisor P, a pending flag, and a counter C (0..D-1).
REQ-016 With en=1 and clr=0, C SHALL increment each cycle; at C==D-1, C SHALL wrap to 0 and tick[ch] SHALL be 1 on the following cycle only.
REQ-017 tick SHALL be registered: exactly one high cycle per D enabled cycles; first tick D cycles after rst release with en held high.
REQ-018 With en=0, C SHALL hold and tick SHALL be 0; counting resumes from the held value.
REQ-019 clr=1 SHALL zero all C and all tick on the next edge regardless of en; clr has priority over en.
REQ-020 div_wr with div_sel<NUM_CH and div_val>=2 SHALL load P, set the pending flag, and pulse div_ack the next cycle.
REQ-021 div_wr with div_val<2 or div_sel>=NUM_CH SHALL change no state and pulse div_err the next cycle.
REQ-022 A pending P SHALL become D at that channel's next wrap (the wrap that emits a tick), clearing the flag; the current period completes with the old D.
REQ-023 A second accepted write to a channel before its wrap SHALL overwrite P (last write wins).
REQ-024 clr SHALL also transfer every pending P to D immediately.
REQ-025 div_wr coinciding with clr SHALL be accepted, and its value SHALL become D in that same cycle.
REQ-026 div_wr coinciding with a wrap on the same channel: the old P (if any) SHALL apply at this wrap; the new value SHALL become pending.
REQ-027 div_ack and div_err SHALL never assert together and SHALL be 0 when div_wr was 0.
REQ-028 Channels SHALL be fully independent except for shared en and clr.

Reset
REQ-029 rst low SHALL asynchronously force: all C=0, all D=CLK_HZ, all P=CLK_HZ, pending flags=0, tick=0, div_ack=0, div_err=0, phase=0.
REQ-030 Reset asserted mid-period SHALL discard pending writes; after release, counting restarts from 0 with D=CLK_HZ.
REQ-031 Reset release SHALL be synchronised externally; no internal synchroniser.

Configuration
REQ-032 Macro TIMEBASE_PHASE_OUT_EN SHALL control the phase output.
REQ-033 Defined: phase[ch] SHALL be registered high while C < D/2 (integer division) and low otherwise, frozen when en=0, 0 after clr or reset.
REQ-034 Undefined: the phase port and its logic SHALL be absent; all other behaviour identical.

Verification (CLK_HZ=10, NUM_CH=4, CNT_W=8)
REQ-035 Release rst, en=1 for 35 cycles -> tick[0..3] pulse at cycles 10, 20, 30, each one cycle wide.
REQ-036 div_wr ch1 val=4 at cycle 3 -> div_ack at cycle 4; tick[1] at 10, then 14, 18, 22; other channels unchanged.
REQ-037 div_wr val=1, then div_sel=5 -> div_err each, no ack, tick timing unchanged.
REQ-038 en low cycles 5-9 -> no ticks, first tick[0] at cycle 15; clr at cycle 12 with pending ch2 val=3 -> tick[2] 3 cycles after clr.
REQ-039 rst low at cycle 7 of a period after a pending write -> all outputs 0 immediately; after release ticks every 10 cycles.
REQ-040 With TIMEBASE_PHASE_OUT_EN, D=10 -> phase[0] high 5 cycles, low 5 cycles; D=5 -> high 2, low 3.
